// File: rtl/aes128_round_sequencer_pkg.sv
// aes128_round_sequencer_pkg: shared AES-128 constants, FSM encoding and GF(2^8) round-datapath functions
package aes128_round_sequencer_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_NR = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ a : p;
      a = xtime(a);
    end
    return p;
  endfunction
  // S-box as multiplicative inverse (a^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      r = e[i] ? gmul(r, a) : r;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox(s[8*i +: 8]);
    return s;
  endfunction
  // byte n = row + 4*col sits at [127-8n -: 8]; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction
endpackage

// File: rtl/aes128_round_sequencer_key_step.sv
// aes128_key_step: combinational AES-128 key expansion step producing the next round key
module aes128_key_step
  import aes128_round_sequencer_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] rk,
  input  logic [7:0]             rc,
  output logic [AES_BLOCK_W-1:0] nk
);
  logic [31:0] rot;
  logic [31:0] sw;
  logic [31:0] t;
  logic [31:0] w0, w1, w2, w3;
  assign rot = {rk[23:0], rk[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sw[8*i +: 8] = sbox(rot[8*i +: 8]);
  end
  assign t = sw ^ {rc, 24'h0};
  assign w0 = rk[127:96] ^ t;
  assign w1 = rk[95:64] ^ w0;
  assign w2 = rk[63:32] ^ w1;
  assign w3 = rk[31:0] ^ w2;
  assign nk = {w0, w1, w2, w3};
endmodule

// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion
module aes128_round_sequencer
  import aes128_round_sequencer_pkg::*;
#(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic [AES_BLOCK_W-1:0] in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy,
  output logic [RW-1:0]          round
);
  if (NR != AES_NR) begin : g_nr_check
    $error("aes128_round_sequencer: NR must be 10");
  end
  fsm_e fsm_q, fsm_d;
  logic [RW-1:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic [AES_BLOCK_W-1:0] state_q, state_d, rk_q, rk_d;
  logic [AES_BLOCK_W-1:0] rk_next, sr, rnd;
  logic last;
  aes128_key_step u_key_step (.rk(rk_q), .rc(rcon_q), .nk(rk_next));
  assign last = round_q == RW'(NR);
  // one cipher round on the current state; the final round skips mixColumns
  always_comb begin
    sr = shift_rows(sub_bytes(state_q));
    rnd = (last ? sr : mix_columns(sr)) ^ rk_next;
  end
  // next-state logic: accept in IDLE, iterate rounds, hold result in DONE until taken
  always_comb begin
    fsm_d = fsm_q;
    round_d = round_q;
    rcon_d = rcon_q;
    state_d = state_q;
    rk_d = rk_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        state_d = in_data ^ in_key;
        rk_d = in_key;
        rcon_d = AES_RCON_INIT;
        round_d = RW'(1);
        fsm_d = ROUND;
      end
      ROUND: begin
        state_d = rnd;
        rk_d = rk_next;
        rcon_d = xtime(rcon_q);
        fsm_d = last ? DONE : ROUND;
        round_d = last ? round_q : round_q + RW'(1);
      end
      DONE: if (out_ready) begin
        fsm_d = IDLE;
        round_d = '0;
      end
      default: fsm_d = IDLE;
    endcase
  end
  // state registers, all cleared by reset so an interrupted block leaves no trace
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      round_q <= '0;
      rcon_q <= '0;
      state_q <= '0;
      rk_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      round_q <= round_d;
      rcon_q <= rcon_d;
      state_q <= state_d;
      rk_q <= rk_d;
    end
  end
  assign in_ready = fsm_q == IDLE;
  assign out_valid = fsm_q == DONE;
  assign busy = fsm_q != IDLE;
  assign out_data = state_q;
  assign round = round_q;
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb_aes128_round_sequencer: directed FIPS-197 vectors plus backpressure, back-to-back and reset sequences
module tb_aes128_round_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [127:0] out_data;
  logic busy;
  logic [3:0] round;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [3];
  aes128_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .round(round)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic accept(input logic [127:0] key, input logic [127:0] pt);
    @(negedge clk);
    chk("accept_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_key = key;
    in_data = pt;
    @(negedge clk);
    in_valid = 1'b0;
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_data = {$urandom, $urandom, $urandom, $urandom};
    chk("accept_round1", round, 1);
    chk("accept_busy", busy, 1);
    chk("accept_in_ready_low", in_ready, 0);
  endtask
  task automatic wait_done(input logic [127:0] ct);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      chk("round_count", round, n + 1);
      @(negedge clk);
      n++;
    end
    chk("latency", n, 10);
    chk("done_round", round, 10);
    chk("done_busy", busy, 1);
    chk("ciphertext", out_data, ct);
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_round", round, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_busy", busy, 0);
  endtask
  initial begin
    int acc [$];
    int ov;
    int m;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_round", round, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      accept(vecs[i].key, vecs[i].pt);
      wait_done(vecs[i].ct);
      handshake();
    end
    accept(vecs[0].key, vecs[0].pt);
    wait_done(vecs[0].ct);
    in_valid = 1'b1;
    in_key = vecs[1].key;
    in_data = vecs[1].pt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, vecs[0].ct);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_round", round, 10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);
    chk("bp_hs_round", round, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_reaccept_round", round, 1);
    chk("bp_reaccept_busy", busy, 1);
    wait_done(vecs[1].ct);
    handshake();
    in_valid = 1'b1;
    in_key = vecs[0].key;
    in_data = vecs[0].pt;
    out_ready = 1'b1;
    ov = 0;
    for (int cyc = 0; cyc < 41; cyc++) begin
      if (in_ready) acc.push_back(cyc);
      if (acc.size() > 0) begin
        m = (cyc - acc[0]) % 12;
        chk("b2b_round", round, m == 0 ? 0 : (m <= 10 ? m : 10));
      end
      if (out_valid) begin
        ov++;
        chk("b2b_out_data", out_data, vecs[0].ct);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 4);
    for (int k = 1; k < acc.size(); k++) chk("b2b_interval", acc[k] - acc[k-1], 12);
    chk("b2b_outputs", ov, 3);
    repeat (14) @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_drain_in_ready", in_ready, 1);
    accept(vecs[0].key, vecs[0].pt);
    for (int i = 0; i < 20 && round != 5; i++) @(negedge clk);
    chk("rst_mid_round", round, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_round0", round, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (12) begin
      @(negedge clk);
      chk("rst_mid_no_output", out_valid, 0);
    end
    accept(vecs[1].key, vecs[1].pt);
    wait_done(vecs[1].ct);
    handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
